// File: rtl/servo_scan_ctrl_if.sv
// Scan-chain and result-beat bundle between the servo scan controller and its neighbours.
// Master is the controller side; slave is the counter chain plus result consumer.
interface servo_scan_ctrl_if;
    logic        scan_en;
    logic        scan_in;
    logic        scan_ret;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_ch;
    logic [1:0]  res_status;
    logic [11:0] res_width;

    modport master (
        output scan_en, scan_in, res_valid, res_ch, res_status, res_width,
        input  scan_ret, res_ready
    );

    modport slave (
        input  scan_en, scan_in, res_valid, res_ch, res_status, res_width,
        output scan_ret, res_ready
    );
endinterface

// File: rtl/servo_scan_ctrl.sv
// Frames servo pulse counters: clear chain, measure, shift results out, drain one beat per channel.
// Beats follow the shift with zero added latency; res_ready stalls hold the beat, and a stall past the frame deadline pulses overrun.
module servo_scan_ctrl #(
    parameter int NCH         = 4,
    parameter int FRAME_TICKS = 20000,
    parameter int CH_BITS     = 14
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    servo_scan_ctrl_if.master io_scan,
    output logic              o_overrun
);

    localparam int SHIFT_LEN = NCH * CH_BITS;
    localparam int BW        = $clog2(SHIFT_LEN + 1);
    localparam int FW        = $clog2(FRAME_TICKS);

    localparam logic [BW-1:0] BIT_LAST   = BW'(SHIFT_LEN - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [3:0]    CH_LAST    = 4'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SHIFT,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    logic [BW-1:0]          r_bit_cnt;
    logic [FW-1:0]          r_frame_cnt;
    logic [SHIFT_LEN-1:0]   r_capture;
    logic                   r_scan_en;
    logic                   r_res_valid;
    logic [3:0]             r_res_ch;
    logic                   r_overrun;
    logic                   r_missed;

    logic                   w_shift_done;
    logic                   w_frame_term;
    logic                   w_beat_acc;
    logic                   w_last_acc;
    logic [SHIFT_LEN-1:0]   w_cap_next;

    assign w_shift_done = (r_bit_cnt == BIT_LAST);
    assign w_frame_term = (r_frame_cnt == FRAME_LAST);
    assign w_beat_acc   = r_res_valid & io_scan.res_ready;
    assign w_last_acc   = w_beat_acc & (r_res_ch == CH_LAST);
    assign w_cap_next   = {r_capture[SHIFT_LEN-2:0], io_scan.scan_ret};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_frame_cnt <= '0;
            r_capture   <= '0;
            r_scan_en   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= 4'd0;
            r_overrun   <= 1'b0;
            r_missed    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_frame_cnt <= '0;
                    if (i_enable) begin
                        r_state   <= S_CLEAR;
                        r_scan_en <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end

                S_CLEAR: begin
                    r_bit_cnt <= r_bit_cnt + BIT_ONE;
                    if (w_shift_done) begin
                        r_scan_en   <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_frame_cnt <= '0;
                        r_state     <= i_enable ? S_MEASURE : S_IDLE;
                    end
                end

                S_MEASURE: begin
                    if (!i_enable) begin
                        r_state     <= S_IDLE;
                        r_frame_cnt <= '0;
                    end else if (w_frame_term) begin
                        r_state   <= S_SHIFT;
                        r_scan_en <= 1'b1;
                        r_bit_cnt <= '0;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + FRAME_ONE;
                    end
                end

                S_SHIFT: begin
                    r_capture <= w_cap_next;
                    r_bit_cnt <= r_bit_cnt + BIT_ONE;
                    // Next frame's window opens as the shift completes, overlapping the drain.
                    if (w_shift_done) begin
                        r_scan_en   <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_frame_cnt <= '0;
                        r_missed    <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_ch    <= 4'd0;
                        r_state     <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (!w_frame_term) begin
                        r_frame_cnt <= r_frame_cnt + FRAME_ONE;
                    end else if (!r_missed && !w_last_acc) begin
                        r_overrun <= 1'b1;
                        r_missed  <= 1'b1;
                    end
                    // Capture shifts down one channel per beat so the current beat always sits in the low bits.
                    if (w_beat_acc) begin
                        r_capture <= r_capture >> CH_BITS;
                        r_res_ch  <= r_res_ch + 4'd1;
                        if (r_res_ch == CH_LAST) begin
                            r_res_valid <= 1'b0;
                            r_res_ch    <= 4'd0;
                            if (!i_enable) begin
                                r_state     <= S_IDLE;
                                r_frame_cnt <= '0;
                            end else if (w_frame_term) begin
                                r_state   <= S_SHIFT;
                                r_scan_en <= 1'b1;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= S_MEASURE;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_scan.scan_en    = r_scan_en;
    assign io_scan.scan_in    = 1'b0;
    assign io_scan.res_valid  = r_res_valid;
    assign io_scan.res_ch     = r_res_ch;
    assign io_scan.res_status = r_capture[CH_BITS-1 -: 2];
    assign io_scan.res_width  = r_capture[CH_BITS-3:0];
    assign o_overrun          = r_overrun;

endmodule

// File: tb/tb_servo_scan_ctrl.sv
// Bench for servo_scan_ctrl: behavioural counter chain, table of per-frame pulse vectors, plus overrun/reset/idle/overflow sequences.
module tb_servo_scan_ctrl;

    logic clk;
    logic rst_a, en_a, overrun_a;
    logic rst_b, en_b, overrun_b;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;
    bit   b_done   = 0;

    servo_scan_ctrl_if bus_a ();
    servo_scan_ctrl_if bus_b ();

    servo_scan_ctrl #(.NCH(2), .FRAME_TICKS(100), .CH_BITS(14)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_enable(en_a), .io_scan(bus_a), .o_overrun(overrun_a)
    );

    servo_scan_ctrl #(.NCH(2), .FRAME_TICKS(5000), .CH_BITS(14)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_enable(en_b), .io_scan(bus_b), .o_overrun(overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter chain model: ch k lives at [14k+13:14k]; chain shifts toward ch NCH-1, whose MSB returns.
    logic [27:0] chain_a = 28'h9A5C3F1;
    logic [27:0] chain_b = 28'h6D2E7B4;
    int start_a [2] = '{0, 0};
    int len_a   [2] = '{0, 0};
    int start_b [2] = '{0, 0};
    int len_b   [2] = '{0, 0};

    assign bus_a.scan_ret = chain_a[27];
    assign bus_b.scan_ret = chain_b[27];

    function automatic logic [13:0] chan_upd(input logic [13:0] c, input logic p);
        logic [13:0] r;
        r = c;
        case (c[13:12])
            2'b00: if (p) r = {2'b01, 12'd1};
            2'b01: begin
                if (!p)                   r = {2'b10, c[11:0]};
                else if (c[11:0] == 12'hFFF) r = {2'b11, c[11:0]};
                else                      r = {2'b01, c[11:0] + 12'd1};
            end
            default: r = c;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.scan_en) chain_a <= {chain_a[26:0], bus_a.scan_in};
        else for (int k = 0; k < 2; k++)
            chain_a[k*14 +: 14] <= chan_upd(chain_a[k*14 +: 14],
                                            (cyc >= start_a[k]) && (cyc < start_a[k] + len_a[k]));
        if (bus_b.scan_en) chain_b <= {chain_b[26:0], bus_b.scan_in};
        else for (int k = 0; k < 2; k++)
            chain_b[k*14 +: 14] <= chan_upd(chain_b[k*14 +: 14],
                                            (cyc >= start_b[k]) && (cyc < start_b[k] + len_b[k]));
    end

    typedef struct {
        int          len0;
        int          len1;
        logic [1:0]  st0;
        logic [1:0]  st1;
        logic [11:0] w0;
        logic [11:0] w1;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_pulses_a(input int l0, input int l1);
        start_a[0] = cyc + 5; len_a[0] = l0;
        start_a[1] = cyc + 5; len_a[1] = l1;
    endtask

    task automatic wait_shift(output int low, output int high, output int vld);
        int n;
        low = 0; high = 0; vld = 0; n = 0;
        while (!bus_a.scan_en && n < 1000) begin
            if (bus_a.res_valid) vld++;
            low++; n++;
            @(negedge clk);
        end
        while (bus_a.scan_en && n < 1000) begin
            if (bus_a.res_valid) vld++;
            high++; n++;
            @(negedge clk);
        end
        chk("shift_wait_timeout", int'(n >= 1000), 0);
    endtask

    task automatic collect(input vec_t v, input bit rnd);
        int          got, n;
        bit          stalled;
        logic [3:0]  h_ch;
        logic [1:0]  h_st, e_st;
        logic [11:0] h_w, e_w;
        got = 0; n = 0; stalled = 0;
        h_ch = '0; h_st = '0; h_w = '0;
        while (got < 2 && n < 300) begin
            bus_a.res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus_a.res_valid) begin
                if (stalled) begin
                    chk("stall_ch", bus_a.res_ch, h_ch);
                    chk("stall_status", bus_a.res_status, h_st);
                    chk("stall_width", bus_a.res_width, h_w);
                end
                e_st = (got == 0) ? v.st0 : v.st1;
                e_w  = (got == 0) ? v.w0  : v.w1;
                if (bus_a.res_ready) begin
                    chk("beat_ch", bus_a.res_ch, got);
                    chk("beat_status", bus_a.res_status, e_st);
                    if (e_st == 2'b10) chk("beat_width", bus_a.res_width, e_w);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    h_ch = bus_a.res_ch; h_st = bus_a.res_status; h_w = bus_a.res_width;
                end
            end
            @(negedge clk);
            n++;
        end
        bus_a.res_ready = 1'b1;
        chk("beats_received", got, 2);
    endtask

    vec_t vecs [6];
    vec_t ovr_vec, rst_vec;

    initial begin
        int low, high, vld, n, cnt;
        vecs[0] = '{37,  0, 2'b10, 2'b00, 12'd37, 12'd0};
        vecs[1] = '{0,  12, 2'b00, 2'b10, 12'd0,  12'd12};
        vecs[2] = '{115, 50, 2'b01, 2'b10, 12'd0, 12'd50};
        vecs[3] = '{0,   0, 2'b00, 2'b00, 12'd0,  12'd0};
        vecs[4] = '{1,  94, 2'b10, 2'b10, 12'd1,  12'd94};
        vecs[5] = '{88,  3, 2'b10, 2'b10, 12'd88, 12'd3};
        ovr_vec = '{20,  0, 2'b10, 2'b00, 12'd20, 12'd0};
        rst_vec = '{60,  7, 2'b10, 2'b10, 12'd60, 12'd7};

        rst_a = 1'b1; en_a = 1'b1; bus_a.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_scan_en", bus_a.scan_en, 0);
        chk("rst_scan_in", bus_a.scan_in, 0);
        chk("rst_res_valid", bus_a.res_valid, 0);
        chk("rst_res_ch", bus_a.res_ch, 0);
        chk("rst_overrun", overrun_a, 0);
        rst_a = 1'b0;

        // Frame i measures vecs[i] while draining results of vecs[i-1].
        for (int i = 0; i < 6; i++) begin
            wait_shift(low, high, vld);
            chk("shift_len", high, 28);
            if (i == 1) chk("measure_len", low, 100);
            set_pulses_a(vecs[i].len0, vecs[i].len1);
            if (i > 0) begin
                collect(vecs[i-1], i >= 3);
                chk("no_extra_beat", bus_a.res_valid, 0);
            end
        end

        // Stall the drain past the frame deadline.
        wait_shift(low, high, vld);
        chk("shift_len", high, 28);
        set_pulses_a(ovr_vec.len0, ovr_vec.len1);
        bus_a.res_ready = 1'b0;
        cnt = 0; n = 0;
        for (int t = 0; t < 130; t++) begin
            if (overrun_a) cnt++;
            if (bus_a.scan_en || !bus_a.res_valid || bus_a.res_ch != 4'd0) n++;
            @(negedge clk);
        end
        chk("overrun_pulses", cnt, 1);
        chk("stall_hold", n, 0);
        collect(vecs[5], 0);
        chk("shift_after_accept", bus_a.scan_en, 1);
        wait_shift(low, high, vld);
        chk("shift_len_ovr", high, 28);
        collect(ovr_vec, 0);
        chk("no_extra_beat", bus_a.res_valid, 0);

        // Reset in the middle of a shift.
        n = 0;
        while (!bus_a.scan_en && n < 300) begin @(negedge clk); n++; end
        chk("reach_shift", bus_a.scan_en, 1);
        repeat (10) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("midrst_scan_en", bus_a.scan_en, 0);
        chk("midrst_res_valid", bus_a.res_valid, 0);
        chk("midrst_res_ch", bus_a.res_ch, 0);
        @(negedge clk);
        rst_a = 1'b0;
        wait_shift(low, high, vld);
        chk("clear_len", high, 28);
        chk("clear_no_beats", vld, 0);
        chk("clear_after_idle", int'(low > 0), 1);
        set_pulses_a(rst_vec.len0, rst_vec.len1);
        wait_shift(low, high, vld);
        chk("measure_len_rst", low, 100);
        chk("shift_len_rst", high, 28);
        collect(rst_vec, 1);
        chk("no_extra_beat", bus_a.res_valid, 0);

        // Drop enable in MEASURE: straight to IDLE, then CLEAR on re-enable.
        en_a = 1'b0;
        cnt = 0;
        for (int t = 0; t < 200; t++) begin
            if (bus_a.scan_en || bus_a.res_valid) cnt++;
            @(negedge clk);
        end
        chk("idle_quiet", cnt, 0);
        en_a = 1'b1;
        wait_shift(low, high, vld);
        chk("reenable_clear_len", high, 28);

        n = 0;
        while (!b_done && n < 10000) begin @(negedge clk); n++; end
        chk("overflow_seq_done", b_done, 1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Long-frame instance: a pulse beyond 4095 cycles reports overflow.
    initial begin
        int n;
        rst_b = 1'b1; en_b = 1'b1; bus_b.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        n = 0;
        while (!bus_b.scan_en && n < 200) begin @(negedge clk); n++; end
        while (bus_b.scan_en && n < 400) begin @(negedge clk); n++; end
        start_b[0] = cyc + 5; len_b[0] = 4200;
        start_b[1] = cyc + 5; len_b[1] = 10;
        n = 0;
        while (!bus_b.res_valid && n < 6000) begin @(negedge clk); n++; end
        chk("ovf_valid", bus_b.res_valid, 1);
        chk("ovf_ch0", bus_b.res_ch, 0);
        chk("ovf_status0", bus_b.res_status, 3);
        @(negedge clk);
        chk("ovf_ch1", bus_b.res_ch, 1);
        chk("ovf_status1", bus_b.res_status, 2);
        chk("ovf_width1", bus_b.res_width, 10);
        chk("ovf_no_overrun", overrun_b, 0);
        b_done = 1'b1;
    end

endmodule
